mem_writeback: RTL and testbench
================================

Name: mem_writeback

Overview:
- Memory/writeback stage that consumes the execute stage's outputs: ALU result as address or result, rd2 as store data, and rd/funct3/control bits.
- Performs load/store transactions on a data-memory request/ready bus.
- Returns the register-file write port (wb_we/wb_rd/wb_data) back to execute.
- Holds a simple FSM and stalls upstream via in_ready while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles to wait for dmem_ready before aborting; 0 disables the timeout counter.
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  execute presents an instruction this cycle
- in_ready  output  1  stage can accept; high only in IDLE
- alu_result  input  32  address for mem ops, else writeback value
- store_data  input  32  rd2 from execute
- rd  input  5  destination register
- funct3  input  3  access size/sign
- mem_read  input  1  load
- mem_write  input  1  store
- reg_write  input  1  instruction writes rd
- dmem_req  output  1  bus request, held until dmem_ready
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  bus completes access this cycle
- dmem_rdata  input  32  load data, valid when dmem_ready=1
- wb_we  output  1  register write strobe (one cycle)
- wb_rd  output  5  write address
- wb_data  output  32  write data
- bus_err  output  1  one-cycle pulse on timeout abort
- misalign_err  output  1  one-cycle pulse on misaligned access (tied 0 without feature)

Behaviour:
- Reset (async): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, wb_we=0, wb_rd=0, wb_data=0, bus_err=0, misalign_err=0, timeout count=0. Reset mid-access drops dmem_req immediately; the pending instruction is discarded with no writeback.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE), registered-state derived with no combinational path from dmem_ready.
- States:
  - IDLE:
    - Non-memory accept: next cycle wb_we=reg_write&&(rd!=0), wb_data=alu_result, wb_rd=rd; stay IDLE. Latency 1.
    - Memory accept: register addr/be/wdata/funct3/rd; dmem_req=1 from the next cycle; go to ACCESS.
    - mem_write has priority if both mem_read and mem_write are set.
  - ACCESS:
    - dmem_req, dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable.
    - On dmem_ready=1: dmem_req=0 next cycle; for loads, next cycle wb_we=reg_write&&(rd!=0) and wb_data=extended data; for stores, wb_we stays 0. Return to IDLE; in_ready is high in that same next cycle. Minimum load latency is 2 cycles from accept.
    - Timeout: count cycles in ACCESS; if TIMEOUT!=0 and the count reaches TIMEOUT without ready, drop dmem_req, pulse bus_err, suppress writeback, and return to IDLE. The counter clears on entry to ACCESS.
- Stores:
  - SB (f3[1:0]=00): be=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH (01): be = addr[1] ? 1100 : 0011, wdata={2{sd[15:0]}}.
  - SW (10/11): be=1111, wdata=sd.
- Loads, byte/half selected by addr[1:0]/addr[1]:
  - LB 000 sign-extend; LBU 100 zero-extend.
  - LH 001 sign-extend; LHU 101 zero-extend.
  - LW 010, and 011/110/111, return the full word.
- wb_we is a single-cycle pulse; wb_rd/wb_data hold their last values when wb_we=0.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0), without feature: access proceeds with the low bits ignored as above.

Optional Feature:
- MISALIGN_TRAP_EN defined: a misaligned memory accept issues no bus access; next cycle misalign_err=1 for one cycle, wb_we=0; stay IDLE.
- Undefined: misalign_err is constant 0 and accesses proceed as in Behaviour.

Decomposition:
- Package riscv_mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE, ACCESS), XLEN.
- One combinational sub-module, load_extend (rdata, addr[1:0], funct3 -> 32-bit result), instantiated by mem_writeback.

Test Plan:
- Non-mem: alu_result=0x1234, rd=5, reg_write=1 -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234; with rd=0 -> wb_we=0.
- LB at 0x1003, rdata=0x80FF_0000, ready after 3 wait cycles:
  - dmem_addr=0x1000 and req held 3 cycles; in_ready=0 throughout.
  - wb_data=0xFFFF_FF80.
  - Same access with LBU -> wb_data=0x0000_0080.
- SH at 0x2002, store_data=0xAAAA_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF; no wb_we.
- TIMEOUT=4, dmem_ready never asserted -> req drops after 4 ACCESS cycles, bus_err pulses once, no wb_we, in_ready returns 1.
- Reset asserted during ACCESS -> dmem_req=0 immediately; after release, state IDLE and no wb_we.
- MISALIGN_TRAP_EN, LW at 0x3001 -> dmem_req never asserted, misalign_err pulses once, wb_we=0; without macro -> bus access at 0x3000 with be=1111.

Source files
------------

// File: rtl/mem_writeback_pkg.sv
// Shared types and helpers for the memory/writeback stage.
// Funct3 encodings, FSM states and store lane/byte-enable helpers.
package riscv_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Size comes from funct3[1:0]: 00 byte, 01 half, 1x word.
    function automatic logic [3:0] byte_en(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_data(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] sd
    );
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// Data-memory request/ready bus between the stage and memory.
interface mem_writeback_if;
    import riscv_mem_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_writeback_load_extend.sv
// Load data lane select and sign/zero extension.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      b;
    logic [15:0]     h;

    assign shifted = rdata >> {addr, 3'b000};
    assign b       = shifted[7:0];
    assign h       = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'h0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'h0, h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: one outstanding load/store, register writeback.
// Optional MISALIGN_TRAP_EN turns misaligned accesses into misalign_err.
module mem_writeback #(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    mem_writeback_if.master dmem,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            bus_err,
    output logic            misalign_err
);
    import riscv_mem_pkg::*;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t state, state_nx;

    logic            accept;
    logic            mem_op;
    logic            trap;
    logic            timeout_hit;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic [XLEN-1:0] ext;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign mem_op   = mem_read || mem_write;

    // Ready in the final allowed cycle still completes the access.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST)
                         && !dmem.dmem_ready;

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(funct3, alu_result[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_err <= 1'b0;
        else
            misalign_err <= accept && mem_op && trap;
    end
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    load_extend u_ext (
        .rdata  (dmem.dmem_rdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .result (ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (accept && mem_op && !trap)
                    state_nx = ACCESS;
            ACCESS:
                if (dmem.dmem_ready || timeout_hit)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= 4'b0000;
            wb_we           <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= '0;
            bus_err         <= 1'b0;
            cnt             <= '0;
            f3_q            <= 3'b000;
            lo_q            <= 2'b00;
            rd_q            <= 5'd0;
            rw_q            <= 1'b0;
        end else begin
            wb_we   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept && mem_op && !trap) begin
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= mem_write;
                        dmem.dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                        dmem.dmem_be    <= byte_en(funct3, alu_result[1:0]);
                        dmem.dmem_wdata <= lane_data(funct3, store_data);
                        f3_q            <= funct3;
                        lo_q            <= alu_result[1:0];
                        rd_q            <= rd;
                        rw_q            <= reg_write;
                    end else if (accept && !mem_op
                                 && reg_write && rd != 5'd0) begin
                        wb_we   <= 1'b1;
                        wb_rd   <= rd;
                        wb_data <= alu_result;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ready) begin
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        if (!dmem.dmem_we && rw_q && rd_q != 5'd0) begin
                            wb_we   <= 1'b1;
                            wb_rd   <= rd_q;
                            wb_data <= ext;
                        end
                    end else if (timeout_hit) begin
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        bus_err       <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback with a scripted memory responder.
module tb_mem_writeback;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;
    logic        misalign_err;

    mem_writeback_if bus();

    mem_writeback #(.TIMEOUT(4), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd           (rd),
        .funct3       (funct3),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .dmem         (bus),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t wb_q[$];
    int  berr_q[$];
    int  mis_q[$];

    int total  = 0;
    int passed = 0;

    int          req_n      = 0;
    int          last_req_n = 0;
    int          req_total  = 0;
    int          wait_n     = 1;
    logic        never_ready = 1'b0;
    logic [31:0] rdata_v    = 32'h0;
    logic [31:0] exp_addr   = 32'h0;
    logic [31:0] exp_wdata  = 32'h0;
    logic [3:0]  exp_be     = 4'h0;
    logic        exp_we     = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory responder: checks the request stays stable, answers after wait_n.
    always @(negedge clk) begin
        if (reset || !bus.dmem_req) begin
            if (req_n != 0)
                last_req_n = req_n;
            req_n          = 0;
            bus.dmem_ready = 1'b0;
        end else begin
            req_n++;
            req_total++;
            check("in_ready_busy", {31'b0, in_ready}, 32'd0);
            check("dmem_addr", bus.dmem_addr, exp_addr);
            check("dmem_be", {28'b0, bus.dmem_be}, {28'b0, exp_be});
            check("dmem_wdata", bus.dmem_wdata, exp_wdata);
            check("dmem_we", {31'b0, bus.dmem_we}, {31'b0, exp_we});
            bus.dmem_ready = !never_ready && (req_n == wait_n);
            bus.dmem_rdata = rdata_v;
        end
    end

    // Monitor: every writeback / error pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_we) begin
                if (wb_q.size() == 0) begin
                    total++;
                    $display("FAIL wb_unexpected: wb_we=1 rd=%0d data=%h, expected no write",
                             wb_rd, wb_data);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                    check("wb_data", wb_data, e.data);
                end
            end
            if (bus_err) begin
                total++;
                if (berr_q.size() == 0)
                    $display("FAIL bus_err_unexpected: got 1, expected 0");
                else begin
                    void'(berr_q.pop_front());
                    passed++;
                end
            end
            if (misalign_err) begin
                total++;
                if (mis_q.size() == 0)
                    $display("FAIL misalign_unexpected: got 1, expected 0");
                else begin
                    void'(mis_q.pop_front());
                    passed++;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic rw);
        @(negedge clk);
        alu_result = a;
        store_data = sd;
        rd         = r;
        funct3     = f3;
        mem_read   = mr;
        mem_write  = mw;
        reg_write  = rw;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(in_ready && !bus.dmem_req) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (n < 40)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_bus(input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic we);
        exp_addr  = a;
        exp_be    = be;
        exp_wdata = wd;
        exp_we    = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        alu_result     = 32'h0;
        store_data     = 32'h0;
        rd             = 5'd0;
        funct3         = 3'b000;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        #12;
        check("rst_req", {31'b0, bus.dmem_req}, 32'd0);
        check("rst_we", {31'b0, bus.dmem_we}, 32'd0);
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_be", {28'b0, bus.dmem_be}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_wb_we", {31'b0, wb_we}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Non-memory writeback, one-cycle latency.
        wb_q.push_back('{5'd5, 32'h0000_1234});
        issue(32'h1234, 32'h0, 5'd5, F3_W, 1'b0, 1'b0, 1'b1);
        check("nonmem_latency", {31'b0, wb_we}, 32'd1);
        wait_idle("nonmem_idle");
        issue(32'h5555, 32'h0, 5'd0, F3_W, 1'b0, 1'b0, 1'b1);
        wait_idle("rd0_idle");
        issue(32'h6666, 32'h0, 5'd7, F3_W, 1'b0, 1'b0, 1'b0);
        wait_idle("norw_idle");

        // LB / LBU at 0x1003 with three request cycles.
        rdata_v = 32'h80FF_0000;
        wait_n  = 3;
        expect_bus(32'h1000, 4'b1000, 32'h0, 1'b0);
        wb_q.push_back('{5'd9, 32'hFFFF_FF80});
        issue(32'h1003, 32'h0, 5'd9, F3_B, 1'b1, 1'b0, 1'b1);
        wait_idle("lb_idle");
        check("lb_req_cycles", last_req_n, 32'd3);
        wb_q.push_back('{5'd10, 32'h0000_0080});
        issue(32'h1003, 32'h0, 5'd10, F3_BU, 1'b1, 1'b0, 1'b1);
        wait_idle("lbu_idle");
        check("lbu_req_cycles", last_req_n, 32'd3);

        // Halfword loads with immediate ready (minimum latency).
        wait_n = 1;
        expect_bus(32'h1000, 4'b1100, 32'h0, 1'b0);
        wb_q.push_back('{5'd11, 32'hFFFF_80FF});
        issue(32'h1002, 32'h0, 5'd11, F3_H, 1'b1, 1'b0, 1'b1);
        wait_idle("lh_idle");
        check("lh_req_cycles", last_req_n, 32'd1);
        wb_q.push_back('{5'd12, 32'h0000_80FF});
        issue(32'h1002, 32'h0, 5'd12, F3_HU, 1'b1, 1'b0, 1'b1);
        wait_idle("lhu_idle");

        rdata_v = 32'hDEAD_BEEF;
        expect_bus(32'h1004, 4'b1111, 32'h0, 1'b0);
        wb_q.push_back('{5'd14, 32'hDEAD_BEEF});
        issue(32'h1004, 32'h0, 5'd14, F3_W, 1'b1, 1'b0, 1'b1);
        wait_idle("lw_idle");

        // Stores never write back, even with reg_write set.
        wait_n = 2;
        expect_bus(32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        issue(32'h2002, 32'hAAAA_BEEF, 5'd3, F3_H, 1'b0, 1'b1, 1'b1);
        wait_idle("sh_idle");
        check("sh_req_cycles", last_req_n, 32'd2);
        wait_n = 1;
        expect_bus(32'h4000, 4'b0010, 32'h7878_7878, 1'b1);
        issue(32'h4001, 32'h1234_5678, 5'd3, F3_B, 1'b0, 1'b1, 1'b0);
        wait_idle("sb_idle");
        expect_bus(32'h5000, 4'b1111, 32'hCAFE_F00D, 1'b1);
        issue(32'h5000, 32'hCAFE_F00D, 5'd4, F3_W, 1'b1, 1'b1, 1'b1);
        wait_idle("sw_both_idle");

        // Timeout after four request cycles.
        never_ready = 1'b1;
        expect_bus(32'h6000, 4'b1111, 32'h0, 1'b0);
        berr_q.push_back(1);
        issue(32'h6000, 32'h0, 5'd15, F3_W, 1'b1, 1'b0, 1'b1);
        wait_idle("timeout_idle");
        check("timeout_req_cycles", last_req_n, 32'd4);
        check("timeout_in_ready", {31'b0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of an access.
        expect_bus(32'h7000, 4'b1111, 32'h0, 1'b0);
        issue(32'h7000, 32'h0, 5'd16, F3_W, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_req", {31'b0, bus.dmem_req}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset       = 1'b0;
        never_ready = 1'b0;
        wait_idle("midrst_idle");
        check("midrst_wb_we", {31'b0, wb_we}, 32'd0);

        // Misaligned word load at 0x3001.
        rdata_v = 32'h1122_3344;
        wait_n  = 1;
`ifdef MISALIGN_TRAP_EN
        begin
            int before;
            before = req_total;
            mis_q.push_back(1);
            issue(32'h3001, 32'h0, 5'd13, F3_W, 1'b1, 1'b0, 1'b1);
            wait_idle("mis_idle");
            check("mis_no_req", req_total, before);
        end
`else
        expect_bus(32'h3000, 4'b1111, 32'h0, 1'b0);
        wb_q.push_back('{5'd13, 32'h1122_3344});
        issue(32'h3001, 32'h0, 5'd13, F3_W, 1'b1, 1'b0, 1'b1);
        wait_idle("mis_idle");
        check("mis_req_cycles", last_req_n, 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("wb_queue_empty", wb_q.size(), 32'd0);
        check("bus_err_queue_empty", berr_q.size(), 32'd0);
        check("misalign_queue_empty", mis_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
